data_fetch_engine: RTL and testbench

- Downstream consumer of the descriptor processor's fetch requests (fetch_data / addr_data / length_data).
- Per accepted request: acknowledges it, issues one read burst of length_data 32-bit words at addr_data to the memory read port, and writes returned beats into an internal data FIFO drained by the output stream.
- Owns the FIFO credit counter datafifo_room, which the descriptor processor checks before requesting and debits via subtract_room.

---
 rtl/dma_pkg.sv | 18 +
 rtl/dma_sync_fifo.sv | 75 +++++++
 rtl/data_fetch_engine.sv | 162 ++++++++++++++++
 tb/tb_data_fetch_engine.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA descriptor/fetch datapath.
//   - fetch FSM state encoding
//   - word stride constants, shared with the descriptor processor
//   - default datapath width and data FIFO depth
package dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DATA = 2'b10
   } fetch_state_e;

   localparam int WORD_BYTES     = 4;
   localparam int WORD_SHIFT     = 2;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_FIFO_DEPTH = 32;

endpackage : dma_pkg

// File: rtl/dma_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rstb    : clock, synchronous active-low reset
//   push         : write push_data this cycle (dropped when full)
//   pop          : consume the head word (ignored when empty)
//   out_valid    : head word present; out_data is zero while empty
//   full         : occupancy equals DEPTH
//   drop         : push attempted while full (combinational)
module dma_sync_fifo #(
   parameter int DATA_W = 32,
   parameter int AW     = 5,
   parameter int DEPTH  = 1 << AW
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              full,
   output logic              drop
);

   localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              empty;
   logic              push_ok;
   logic              pop_ok;
   logic [DATA_W-1:0] mem [DEPTH];

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + AW'(1);
   endfunction

   assign empty     = (count_q == '0);
   assign full      = (count_q == FULL_CNT);
   assign push_ok   = push & ~full;
   assign pop_ok    = pop & ~empty;
   assign drop      = push & full;
   assign out_valid = ~empty;
   assign out_data  = empty ? '0 : mem[rd_ptr_q];

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
      if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array has no reset; occupancy gates what is visible, so stale words never escape.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= push_data;
   end

endmodule : dma_sync_fifo

// File: rtl/data_fetch_engine.sv
// Data fetch engine: accepts fetch requests from the descriptor processor,
// issues one memory read burst per request and buffers returned beats in a
// FWFT data FIFO drained by the output stream. Owns the FIFO credit counter.
//   fetch_data/addr_data/length_data/ack_fetch_data : request handshake
//   subtract_room/datafifo_room                     : credit debit / credits
//   mem_rd_req/addr/len/gnt, mem_rd_valid/data      : memory read port
//   out_valid/out_data/out_ready                    : output stream
//   err_sticky                                      : protocol error, reset-only clear
module data_fetch_engine
   import dma_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int AW         = $clog2(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              fetch_data,
   input  logic [31:0]       addr_data,
   input  logic [7:0]        length_data,
   output logic              ack_fetch_data,
   input  logic              subtract_room,
   output logic [7:0]        datafifo_room,
   output logic              mem_rd_req,
   output logic [31:0]       mem_rd_addr,
   output logic [7:0]        mem_rd_len,
   input  logic              mem_rd_gnt,
   input  logic              mem_rd_valid,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              err_sticky
);

   localparam logic signed [9:0] DEPTH_S = 10'(FIFO_DEPTH);

   fetch_state_e state_q, state_d;
   logic         ack_q, ack_d;
   logic         req_q, req_d;
   logic [31:0]  addr_q, addr_d;
   logic [7:0]   len_q, len_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [7:0]   room_q, room_d;
   logic         err_q, err_d;

   logic              push;
   logic              pop;
   logic              stray;
   logic              fifo_drop;
   logic              fifo_full;
   logic              credit_err;
   logic signed [9:0] room_calc;

   assign pop = out_valid & out_ready;

   dma_sync_fifo #(
      .DATA_W (DATA_W),
      .AW     (AW),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstb      (rstb),
      .push      (push),
      .push_data (mem_rd_data),
      .pop       (pop),
      .out_valid (out_valid),
      .out_data  (out_data),
      .full      (fifo_full),
      .drop      (fifo_drop)
   );

   // Fetch FSM next state.
   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      req_d   = req_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      stray   = 1'b0;
      push    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stray = mem_rd_valid;
            if (fetch_data) begin
               ack_d  = 1'b1;
               addr_d = addr_data;
               len_d  = length_data;
               // Zero-length requests are acknowledged without touching memory.
               if (length_data != 8'd0) begin
                  req_d   = 1'b1;
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            stray = mem_rd_valid;
            if (mem_rd_gnt) begin
               req_d   = 1'b0;
               cnt_d   = 8'd0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (mem_rd_valid) begin
               push  = 1'b1;
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == len_q) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Credits: debit and pop credit combine in one signed sum, then clamp.
   always_comb begin
      room_calc  = $signed({2'b00, room_q}) + $signed({9'd0, pop})
                 - (subtract_room ? $signed({2'b00, length_data}) : 10'sd0);
      credit_err = 1'b0;
      room_d     = room_calc[7:0];
      if (room_calc < 10'sd0) begin
         room_d     = 8'd0;
         credit_err = 1'b1;
      end else if (room_calc > DEPTH_S) begin
         room_d     = 8'(FIFO_DEPTH);
         credit_err = 1'b1;
      end
   end

   assign err_d = err_q | stray | fifo_drop | credit_err;

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         room_q  <= 8'(FIFO_DEPTH);
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         room_q  <= room_d;
         err_q   <= err_d;
      end
   end

   assign ack_fetch_data = ack_q;
   assign mem_rd_req     = req_q;
   assign mem_rd_addr    = addr_q;
   assign mem_rd_len     = len_q;
   assign datafifo_room  = room_q;
   assign err_sticky     = err_q;

endmodule : data_fetch_engine

// File: tb/tb_data_fetch_engine.sv
// Self-checking bench for data_fetch_engine. Stimulus pushes expected output
// words into a scoreboard queue; a monitor pops and compares on each handshake.
module tb_data_fetch_engine;

   logic        clk = 1'b0;
   logic        rstb;
   logic        fetch_data;
   logic [31:0] addr_data;
   logic [7:0]  length_data;
   logic        ack_fetch_data;
   logic        subtract_room;
   logic [7:0]  datafifo_room;
   logic        mem_rd_req;
   logic [31:0] mem_rd_addr;
   logic [7:0]  mem_rd_len;
   logic        mem_rd_gnt;
   logic        mem_rd_valid;
   logic [31:0] mem_rd_data;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic        err_sticky;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   data_fetch_engine dut (
      .clk            (clk),
      .rstb           (rstb),
      .fetch_data     (fetch_data),
      .addr_data      (addr_data),
      .length_data    (length_data),
      .ack_fetch_data (ack_fetch_data),
      .subtract_room  (subtract_room),
      .datafifo_room  (datafifo_room),
      .mem_rd_req     (mem_rd_req),
      .mem_rd_addr    (mem_rd_addr),
      .mem_rd_len     (mem_rd_len),
      .mem_rd_gnt     (mem_rd_gnt),
      .mem_rd_valid   (mem_rd_valid),
      .mem_rd_data    (mem_rd_data),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_ready      (out_ready),
      .err_sticky     (err_sticky)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 1ns after the rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a handshake seen at the falling edge pops at the next rising edge.
   always @(negedge clk) begin
      if (rstb && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected actual=%h expected=<none>", out_data);
         end else begin
            check("out_data", out_data, sb.pop_front());
         end
      end
   end

   // Debit credits, fetch, grant after gnt_wait cycles, return nbeats beats.
   task automatic do_burst(input logic [31:0] a, input logic [7:0] n, input logic [31:0] base,
                           input int gnt_wait, input int nbeats, input logic [7:0] exp_room);
      length_data   = n;
      subtract_room = 1'b1;
      step();
      subtract_room = 1'b0;
      check("room_after_debit", {24'd0, datafifo_room}, {24'd0, exp_room});
      fetch_data = 1'b1;
      addr_data  = a;
      step();
      fetch_data = 1'b0;
      check("ack_pulse", {31'd0, ack_fetch_data}, 32'd1);
      check("req_up", {31'd0, mem_rd_req}, 32'd1);
      check("rd_addr", mem_rd_addr, a);
      check("rd_len", {24'd0, mem_rd_len}, {24'd0, n});
      repeat (gnt_wait) step();
      check("req_hold", {31'd0, mem_rd_req}, 32'd1);
      mem_rd_gnt = 1'b1;
      step();
      mem_rd_gnt = 1'b0;
      check("req_dropped", {31'd0, mem_rd_req}, 32'd0);
      for (int i = 0; i < nbeats; i++) begin
         mem_rd_valid = 1'b1;
         mem_rd_data  = base + 32'(i);
         sb.push_back(base + 32'(i));
         step();
      end
      mem_rd_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 80 && (sb.size() != 0 || out_valid); i++) step();
      check("drain_sb_empty", 32'(sb.size()), 32'd0);
      check("drain_out_valid", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rstb = 1'b0; fetch_data = 1'b0; addr_data = '0; length_data = '0;
      subtract_room = 1'b0; mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0;
      mem_rd_data = '0; out_ready = 1'b0;
      step();
      step();
      rstb = 1'b1;
      step();

      // Reset / idle state.
      check("rst_room", {24'd0, datafifo_room}, 32'd32);
      check("rst_req", {31'd0, mem_rd_req}, 32'd0);
      check("rst_addr", mem_rd_addr, 32'd0);
      check("rst_len", {24'd0, mem_rd_len}, 32'd0);
      check("rst_ack", {31'd0, ack_fetch_data}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_err", {31'd0, err_sticky}, 32'd0);

      // Single 8-word burst, streamed out as it arrives.
      out_ready = 1'b1;
      do_burst(32'h0000_1000, 8'd8, 32'h0000_00A0, 3, 8, 8'd24);
      check("ack_one_cycle", {31'd0, ack_fetch_data}, 32'd0);
      drain();
      check("room_restored", {24'd0, datafifo_room}, 32'd32);
      check("burst_err", {31'd0, err_sticky}, 32'd0);

      // Zero-length fetch: ack only.
      length_data = 8'd0;
      fetch_data  = 1'b1;
      step();
      fetch_data = 1'b0;
      check("len0_ack", {31'd0, ack_fetch_data}, 32'd1);
      check("len0_no_req", {31'd0, mem_rd_req}, 32'd0);
      step();
      check("len0_ack_drop", {31'd0, ack_fetch_data}, 32'd0);
      check("len0_no_req2", {31'd0, mem_rd_req}, 32'd0);
      check("len0_room", {24'd0, datafifo_room}, 32'd32);

      // Fill the FIFO with four bursts while the consumer stalls.
      out_ready = 1'b0;
      do_burst(32'h0000_0000, 8'd8, 32'hB000_0000, 1, 8, 8'd24);
      do_burst(32'h0000_0020, 8'd8, 32'hB000_0010, 0, 8, 8'd16);
      do_burst(32'h0000_0040, 8'd8, 32'hB000_0020, 2, 8, 8'd8);
      do_burst(32'h0000_0060, 8'd8, 32'hB000_0030, 0, 8, 8'd0);
      check("full_room", {24'd0, datafifo_room}, 32'd0);
      check("full_flag", {31'd0, dut.u_fifo.full}, 32'd1);
      check("full_out_valid", {31'd0, out_valid}, 32'd1);
      check("full_no_err", {31'd0, err_sticky}, 32'd0);

      // One pop with a simultaneous zero debit.
      length_data   = 8'd0;
      subtract_room = 1'b1;
      out_ready     = 1'b1;
      step();
      subtract_room = 1'b0;
      check("pop_sub0_room", {24'd0, datafifo_room}, 32'd1);

      // Nine more pops reach room 10, then pop + debit 8 together.
      repeat (9) step();
      check("room_ten", {24'd0, datafifo_room}, 32'd10);
      length_data   = 8'd8;
      subtract_room = 1'b1;
      step();
      subtract_room = 1'b0;
      check("pop_sub8_room", {24'd0, datafifo_room}, 32'd3);
      drain();
      check("after_drain_room", {24'd0, datafifo_room}, 32'd24);
      check("after_drain_err", {31'd0, err_sticky}, 32'd0);

      // Stray beat in IDLE sets the sticky error.
      out_ready    = 1'b0;
      mem_rd_valid = 1'b1;
      mem_rd_data  = 32'hDEAD_BEEF;
      step();
      mem_rd_valid = 1'b0;
      check("stray_err", {31'd0, err_sticky}, 32'd1);
      check("stray_not_pushed", {31'd0, out_valid}, 32'd0);

      // Reset in the middle of a burst.
      do_burst(32'h0000_2000, 8'd8, 32'hC000_0000, 0, 3, 8'd16);
      rstb = 1'b0;
      step();
      rstb = 1'b1;
      sb.delete();
      check("midrst_room", {24'd0, datafifo_room}, 32'd32);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out_data", out_data, 32'd0);
      check("midrst_err", {31'd0, err_sticky}, 32'd0);
      check("midrst_req", {31'd0, mem_rd_req}, 32'd0);

      // Late beat from the abandoned burst is stray.
      mem_rd_valid = 1'b1;
      step();
      mem_rd_valid = 1'b0;
      check("late_beat_err", {31'd0, err_sticky}, 32'd1);
      check("late_beat_dropped", {31'd0, out_valid}, 32'd0);

      // Engine is back in IDLE: a fetch is accepted.
      length_data = 8'd0;
      fetch_data  = 1'b1;
      step();
      fetch_data = 1'b0;
      check("post_rst_ack", {31'd0, ack_fetch_data}, 32'd1);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_data_fetch_engine
